// File: rtl/hazard_stall_ctrl_if.sv
// Hazard-unit bus: pipeline status in, freeze/flush/stall controls out.
// HAZARD_PERF_CNT_EN adds the stall_cycles/flush_events counter outputs.
interface hazard_stall_ctrl_if;
    logic        id_valid;
    logic [3:0]  id_srcreg1;
    logic [3:0]  id_srcreg2;
    logic        id_uses_src2;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic [3:0]  ex_dstreg;
    logic        ex_br_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        wb_halt;
    logic        pc_freeze;
    logic        ifid_freeze;
    logic        ifid_flush;
    logic        idex_flush;
    logic        be_stall;
    logic        halted;
    logic        mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    modport master (
        output id_valid, id_srcreg1, id_srcreg2, id_uses_src2,
        output ex_regwrite, ex_memtoreg, ex_dstreg, ex_br_taken,
        output mem_req, mem_ready, wb_halt,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles, flush_events,
`endif
        input  pc_freeze, ifid_freeze, ifid_flush, idex_flush, be_stall, halted, mem_err
    );

    modport slave (
        input  id_valid, id_srcreg1, id_srcreg2, id_uses_src2,
        input  ex_regwrite, ex_memtoreg, ex_dstreg, ex_br_taken,
        input  mem_req, mem_ready, wb_halt,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles, flush_events,
`endif
        output pc_freeze, ifid_freeze, ifid_flush, idex_flush, be_stall, halted, mem_err
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central hazard unit: load-use stall, taken-branch flush, memory-wait stall and halt hold.
// HAZARD_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_ctrl_if.slave   io_hz
);
    typedef enum logic [1:0] {StRun, StMemWait, StHalted} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    logic w_load_use;
    logic w_mem_miss;
    logic w_pc_freeze;
    logic w_ifid_freeze;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_be_stall;

    assign w_load_use = io_hz.id_valid & io_hz.ex_regwrite & io_hz.ex_memtoreg &
                        (io_hz.ex_dstreg != 4'd0) &
                        ((io_hz.ex_dstreg == io_hz.id_srcreg1) |
                         (io_hz.id_uses_src2 & (io_hz.ex_dstreg == io_hz.id_srcreg2)));
    assign w_mem_miss = io_hz.mem_req & ~io_hz.mem_ready;

    always_comb begin
        w_pc_freeze   = 1'b0;
        w_ifid_freeze = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_be_stall    = 1'b0;
        if (!rst) begin
            case (r_state)
                StRun: begin
                    if (io_hz.wb_halt | w_mem_miss) begin
                        w_pc_freeze   = 1'b1;
                        w_ifid_freeze = 1'b1;
                        w_be_stall    = 1'b1;
                    end else if (io_hz.ex_br_taken) begin
                        // Branch beats load-use: the ID instruction is wrong-path anyway.
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_freeze   = 1'b1;
                        w_ifid_freeze = 1'b1;
                        w_idex_flush  = 1'b1;
                    end
                end
                StMemWait, StHalted: begin
                    w_pc_freeze   = 1'b1;
                    w_ifid_freeze = 1'b1;
                    w_be_stall    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StRun;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (io_hz.wb_halt) begin
                        r_state <= StHalted;
                    end else if (w_mem_miss) begin
                        r_state    <= StMemWait;
                        r_wait_cnt <= 8'd1;
                    end
                end
                StMemWait: begin
                    if (io_hz.wb_halt) begin
                        r_state <= StHalted;
                    end else if (io_hz.mem_ready) begin
                        r_state    <= StRun;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
                        if (r_wait_cnt == TimeoutCnt) r_mem_err <= 1'b1;
                    end
                end
                StHalted: ;
                default: r_state <= StRun;
            endcase
        end
    end

    assign io_hz.pc_freeze   = w_pc_freeze;
    assign io_hz.ifid_freeze = w_ifid_freeze;
    assign io_hz.ifid_flush  = w_ifid_flush;
    assign io_hz.idex_flush  = w_idex_flush;
    assign io_hz.be_stall    = w_be_stall;
    assign io_hz.halted      = (r_state == StHalted);
    assign io_hz.mem_err     = r_mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (w_pc_freeze && (r_state != StHalted) && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (w_ifid_flush && (r_flush_events != 16'hFFFF)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign io_hz.stall_cycles = r_stall_cycles;
    assign io_hz.flush_events = r_flush_events;
`else
    // Performance counters not built.
`endif
endmodule
